decode_stage: RTL

Registered RV32I decode stage with a valid/ready handshake on both sides. Sits between the fetch buffer and execute, and is the pipelined successor to the single-cycle decoder. Adds:
- an optional skid buffer
- pipeline flush
- illegal-instruction flagging
- a load-use scoreboard that stalls consumers until writeback clears the pending register.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_stage_if.sv | 28 ++
 rtl/decode_stage_inst_decoder.sv | 66 ++++++
 rtl/decode_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode types: major opcodes, the decoded bundle and operand-use lookup.
package decode_pkg;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_wr_en;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        alu_op_0_sel;
      logic [31:0] imm;
      logic        illegal;
   } dec_bundle_t;

   // Returns {rs2_used, rs1_used} for a major opcode (inst[6:2]).
   function automatic logic [1:0] rs_used(input logic [4:0] opc);
      logic rs1_u;
      logic rs2_u;
      rs1_u = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
      rs2_u = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
      return {rs2_u, rs1_u};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side, flush and writeback signals of the decode stage.
interface decode_stage_if
   import decode_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [XLEN-1:0] in_inst_i;
   logic [XLEN-1:0] in_pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_pc_o;
   dec_bundle_t     out_bundle_o;
   logic            wb_valid_i;
   logic [4:0]      wb_addr_i;

   modport slave (
      input  flush_i, in_valid_i, in_inst_i, in_pc_i, out_ready_i, wb_valid_i, wb_addr_i,
      output in_ready_o, out_valid_o, out_pc_o, out_bundle_o
   );

   modport master (
      output flush_i, in_valid_i, in_inst_i, in_pc_i, out_ready_i, wb_valid_i, wb_addr_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_bundle_o
   );
endinterface

// File: rtl/decode_stage_inst_decoder.sv
// Purely combinational RV32I field/immediate decoder; illegal words are flagged
// and have their side-effect flags and immediate forced to zero.
module inst_decoder
   import decode_pkg::*;
(
   input  logic [31:0] inst,
   output dec_bundle_t bundle
);

   logic [4:0] opc;
   logic       legal;
   logic       writes_rd;

   // Legality, immediate format selection and destination-write qualification.
   always_comb begin
      opc       = inst[6:2];
      legal     = 1'b0;
      writes_rd = 1'b0;
      bundle    = '0;

      if (inst[1:0] == 2'b11) begin
         case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_OP_IMM,
            OPC_OP, OPC_AUIPC, OPC_LUI, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
         endcase
      end

      bundle.opcode       = inst[6:0];
      bundle.funct3       = inst[14:12];
      bundle.rd           = inst[11:7];
      bundle.rs1          = inst[19:15];
      bundle.rs2          = inst[24:20];
      bundle.alu_op_0_sel = inst[30] & (((opc == OPC_OP) && (inst[14:12] == 3'b000)) ||
                                        (inst[14:12] == 3'b101));
      bundle.illegal      = !legal;

      if (legal) begin
         case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
               bundle.imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
               bundle.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
               bundle.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
               bundle.imm = {inst[31:12], 12'h000};
            OPC_JAL:
               bundle.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
               bundle.imm = '0;
         endcase

         case (opc)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
         endcase

         bundle.rd_wr_en  = writes_rd && (inst[11:7] != 5'd0);
         bundle.is_load   = (opc == OPC_LOAD);
         bundle.is_store  = (opc == OPC_STORE);
         bundle.is_branch = (opc == OPC_BRANCH);
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: main/skid holding registers, load-use scoreboard,
// flush and valid/ready handshakes on both sides.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SKID_EN = 1,
   parameter int NREG    = 32
)(
   input  logic           clk_i,
   input  logic           rst_i,
   decode_stage_if.slave  bus
);

   if (XLEN != 32) begin : g_xlen_check
      $error("decode_stage: XLEN must be 32");
   end

   dec_bundle_t     in_dec;
   dec_bundle_t     main_b;
   dec_bundle_t     skid_b;
   logic [XLEN-1:0] main_pc;
   logic [XLEN-1:0] skid_pc;
   logic            main_valid;
   logic            skid_valid;
   logic [NREG-1:0] sb;
   logic [NREG-1:0] wb_clr;
   logic [NREG-1:0] ld_set;
   logic [NREG-1:0] sb_eff;
   logic [1:0]      used;
   logic            rs1_hz;
   logic            rs2_hz;
   logic            hazard;
   logic            out_fire;
   logic            accept;
   logic            in_ready;

   inst_decoder u_dec (
      .inst   (bus.in_inst_i),
      .bundle (in_dec)
   );

   // A writeback clearing a register this cycle already releases its consumer.
   always_comb begin
      wb_clr   = bus.wb_valid_i ? (NREG'(1) << bus.wb_addr_i) : '0;
      out_fire = main_valid & bus.out_ready_i;
      ld_set   = (out_fire && main_b.is_load && (main_b.rd != 5'd0)) ? (NREG'(1) << main_b.rd) : '0;
      sb_eff   = sb & ~wb_clr;
      used     = rs_used(in_dec.opcode[6:2]);

      rs1_hz = used[0] && (in_dec.rs1 != 5'd0) &&
               (sb_eff[in_dec.rs1] ||
                (main_valid && main_b.is_load && (main_b.rd == in_dec.rs1)) ||
                (skid_valid && skid_b.is_load && (skid_b.rd == in_dec.rs1)));
      rs2_hz = used[1] && (in_dec.rs2 != 5'd0) &&
               (sb_eff[in_dec.rs2] ||
                (main_valid && main_b.is_load && (main_b.rd == in_dec.rs2)) ||
                (skid_valid && skid_b.is_load && (skid_b.rd == in_dec.rs2)));
      hazard = rs1_hz | rs2_hz;

      if (SKID_EN != 0) begin
         in_ready = !skid_valid && !hazard && !bus.flush_i && !rst_i;
      end else begin
         in_ready = (!main_valid || bus.out_ready_i) && !hazard && !bus.flush_i && !rst_i;
      end
      accept = bus.in_valid_i & in_ready;
   end

   // Main refills from skid first so ordering is preserved; skid only catches
   // an accept while main is stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_b     <= '0;
         skid_b     <= '0;
         main_pc    <= '0;
         skid_pc    <= '0;
         sb         <= '0;
      end else begin
         sb <= (sb & ~wb_clr) | ld_set;
         if (bus.flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
               main_valid <= 1'b1;
               main_b     <= skid_b;
               main_pc    <= skid_pc;
               skid_valid <= 1'b0;
            end else begin
               main_valid <= accept;
               if (accept) begin
                  main_b  <= in_dec;
                  main_pc <= bus.in_pc_i;
               end
            end
         end else if (accept && (SKID_EN != 0)) begin
            skid_valid <= 1'b1;
            skid_b     <= in_dec;
            skid_pc    <= bus.in_pc_i;
         end
      end
   end

   assign bus.in_ready_o   = in_ready;
   assign bus.out_valid_o  = main_valid & !rst_i;
   assign bus.out_pc_o     = rst_i ? '0 : main_pc;
   assign bus.out_bundle_o = rst_i ? '0 : main_b;

endmodule
